pool1d: RTL and testbench

Parametrised 1D pooling stage for the modulation-classifier datapath. It sits between a convolution layer's serial output and the next layer. It accepts NO_CH channels of signed words, delivered least-significant slice first over BW_IN/SER_BW valid cycles. It emits one pooled word per channel for every POOL input words, using either max or average reduction. A frame-end marker flushes partial windows.

---
 rtl/pool_pkg.sv | 19 +
 rtl/pool1d_ser_deser.sv | 84 ++++++++
 rtl/pool1d.sv | 115 +++++++++++
 tb/tb_pool1d.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and configuration helpers for the 1D pooling stage.
// The accumulator width and configuration checks live here so every user agrees on them.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_t;

    // Average pooling needs log2(POOL) guard bits so a full window cannot overflow.
    function automatic int acc_width(input int bw, input int pool);
        return bw + $clog2(pool);
    endfunction

    function automatic bit cfg_ok(input int bw, input int ser, input int pool);
        return (ser > 0) && (bw % ser == 0) && (pool >= 2) && ((pool & (pool - 1)) == 0);
    endfunction

endpackage

// File: rtl/pool1d_ser_deser.sv
// Slice-to-word assembler shared by all channels: one slice counter, per-channel shifters.
// Emits a one-cycle word valid with the assembled words and a registered copy of last.
module ser_deser
    import pool_pkg::*;
#(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 12,
    parameter int SER_BW = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_vld,
    input  logic                    i_last,
    input  logic [NO_CH*SER_BW-1:0] i_data,
    output logic                    o_word_vld,
    output logic                    o_last,
    output logic [NO_CH*BW_IN-1:0]  o_word
);

    localparam int NSLICE = BW_IN / SER_BW;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_word_vld;
    logic             r_last;
    logic             w_final;

    assign w_final = i_vld && (r_cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_word_vld <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_word_vld <= w_final;
            // last is only meaningful on a word's final slice
            r_last     <= w_final && i_last;
            if (i_vld) begin
                r_cnt <= w_final ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign o_word_vld = r_word_vld;
    assign o_last     = r_last;

    for (genvar ch = 0; ch < NO_CH; ch++) begin : g_ch
        logic [SER_BW-1:0] w_slice;
        logic [BW_IN-1:0]  r_word;

        assign w_slice = i_data[ch*SER_BW +: SER_BW];
        assign o_word[ch*BW_IN +: BW_IN] = r_word;

        if (NSLICE == 1) begin : g_par
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_final) begin
                    r_word <= w_slice;
                end
            end
        end else begin : g_ser
            // Slices enter at the top; after NSLICE-1 shifts the first slice sits at bit 0.
            logic [BW_IN-SER_BW-1:0] r_part;
            logic [BW_IN-1:0]        w_next;

            assign w_next = {w_slice, r_part};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_part <= '0;
                    r_word <= '0;
                end else if (i_vld) begin
                    r_part <= w_next[BW_IN-1:SER_BW];
                    if (w_final) begin
                        r_word <= w_next;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pool1d.sv
// 1D max/average pooling over NO_CH lockstep channels of serially delivered signed words.
// One pooled word per channel per POOL words, or earlier when a frame-end flushes a window.
module pool1d
    import pool_pkg::*;
#(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 12,
    parameter int SER_BW = 4,
    parameter int POOL   = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_in,
    input  logic                    last_in,
    input  logic [NO_CH*SER_BW-1:0] data_in,
    output logic                    vld_out,
    output logic [NO_CH*BW_IN-1:0]  data_out
);

    localparam int         LOG2P  = $clog2(POOL);
    localparam int         ACC_W  = acc_width(BW_IN, POOL);
    localparam int         WIN_W  = LOG2P;
    localparam pool_mode_t MODE_E = (MODE == 1) ? POOL_AVG : POOL_MAX;

    if (!cfg_ok(BW_IN, SER_BW, POOL) || (MODE != 0 && MODE != 1)) begin : g_bad_cfg
        $error("pool1d: unsupported BW_IN/SER_BW/POOL/MODE combination");
    end

    logic                   w_word_vld;
    logic                   w_last;
    logic [NO_CH*BW_IN-1:0] w_word;

    ser_deser #(
        .NO_CH (NO_CH),
        .BW_IN (BW_IN),
        .SER_BW(SER_BW)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (vld_in),
        .i_last    (last_in),
        .i_data    (data_in),
        .o_word_vld(w_word_vld),
        .o_last    (w_last),
        .o_word    (w_word)
    );

    logic [WIN_W-1:0] r_win;
    logic             r_vld;
    logic             w_first;
    logic             w_emit;

    assign w_first = (r_win == '0);
    assign w_emit  = w_word_vld && (w_last || (r_win == WIN_W'(POOL - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= w_emit;
            if (w_word_vld) begin
                r_win <= w_emit ? '0 : r_win + 1'b1;
            end
        end
    end

    assign vld_out = r_vld;

    for (genvar ch = 0; ch < NO_CH; ch++) begin : g_ch
        logic signed [BW_IN-1:0] w_word_ch;
        logic signed [ACC_W-1:0] w_word_ext;
        logic signed [ACC_W-1:0] r_acc;
        logic signed [ACC_W-1:0] w_acc_next;
        logic        [BW_IN-1:0] w_result;
        logic        [BW_IN-1:0] r_out;

        assign w_word_ch  = w_word[ch*BW_IN +: BW_IN];
        assign w_word_ext = {{LOG2P{w_word_ch[BW_IN-1]}}, w_word_ch};

        // A window's first word reloads, so an emit and the next window's first word never merge.
        always_comb begin
            w_acc_next = r_acc;
            if (w_first) begin
                w_acc_next = w_word_ext;
            end else if (MODE_E == POOL_AVG) begin
                w_acc_next = r_acc + w_word_ext;
            end else if (w_word_ext > r_acc) begin
                w_acc_next = w_word_ext;
            end
        end

        // Dropping the low LOG2P bits is an arithmetic shift that floors toward -inf.
        assign w_result = (MODE_E == POOL_AVG) ? w_acc_next[ACC_W-1:LOG2P]
                                               : w_acc_next[BW_IN-1:0];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc <= '0;
                r_out <= '0;
            end else begin
                if (w_word_vld) begin
                    r_acc <= w_acc_next;
                end
                if (w_emit) begin
                    r_out <= w_result;
                end
            end
        end

        assign data_out[ch*BW_IN +: BW_IN] = r_out;
    end

endmodule

// File: tb/tb_pool1d.sv
// Directed bench for pool1d: three instances cover max/parallel, max/serial and average pooling.
// Each instance has an expected-value queue and expected-cycle queue drained by a monitor.
module tb_pool1d;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // instance a: max, POOL=4, parallel; instance c: average, POOL=4, parallel
  logic        vld_a, last_a, vout_a;
  logic [23:0] din_a, dout_a;
  logic        vld_c, last_c, vout_c;
  logic [23:0] din_c, dout_c;
  // instance b: max, POOL=2, 3 slices of 4 bits, 10 channels
  logic         vld_b, last_b, vout_b;
  logic [39:0]  din_b;
  logic [119:0] dout_b;

  pool1d #(.NO_CH(2), .BW_IN(12), .SER_BW(12), .POOL(4), .MODE(0)) u_dut_a (
    .clk(clk), .rst(rst), .vld_in(vld_a), .last_in(last_a), .data_in(din_a),
    .vld_out(vout_a), .data_out(dout_a)
  );

  pool1d #(.NO_CH(10), .BW_IN(12), .SER_BW(4), .POOL(2), .MODE(0)) u_dut_b (
    .clk(clk), .rst(rst), .vld_in(vld_b), .last_in(last_b), .data_in(din_b),
    .vld_out(vout_b), .data_out(dout_b)
  );

  pool1d #(.NO_CH(2), .BW_IN(12), .SER_BW(12), .POOL(4), .MODE(1)) u_dut_c (
    .clk(clk), .rst(rst), .vld_in(vld_c), .last_in(last_c), .data_in(din_c),
    .vld_out(vout_c), .data_out(dout_c)
  );

  logic [127:0] exp_qa[$], exp_qb[$], exp_qc[$];
  int           cyc_qa[$], cyc_qb[$], cyc_qc[$];
  logic [127:0] hold_a = '0, hold_b = '0, hold_c = '0;
  int           pulses_a = 0, pulses_b = 0, pulses_c = 0;
  int           drive_cyc = 0;

  // rows 0,1 -> expected 2; rows 3,4 -> expected 5 (hand-computed signed max per channel)
  int tbl[6][10] = '{
    '{-2048,  5, -7, 100, -100,  2047,   0,  -1, 300, -300},
    '{ 2047,  5, -8,  99,  -99, -2048,   1,  -2, 301,  200},
    '{ 2047,  5, -7, 100,  -99,  2047,   1,  -1, 301,  200},
    '{  -45, -35, -25, -15,  -5,    5,  15,  25,  35,   45},
    '{   45,  35,  25,  15,   5,   -5, -15, -25, -35,  -45},
    '{   45,  35,  25,  15,   5,    5,  15,  25,  35,   45}
  };

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack2(input int a, input int b);
    logic [127:0] r;
    r = '0;
    r[11:0]  = 12'(a);
    r[23:12] = 12'(b);
    return r;
  endfunction

  function automatic logic [127:0] pack_row(input int row);
    logic [127:0] r;
    r = '0;
    for (int ch = 0; ch < 10; ch++) r[ch*12 +: 12] = 12'(tbl[row][ch]);
    return r;
  endfunction

  // ---------------- monitors / scoreboards ----------------
  always @(negedge clk) begin
    if (rst) hold_a = '0;
    else if (vout_a) begin
      pulses_a++;
      if (exp_qa.size() == 0) check("a_unexpected", 128'(vout_a), '0);
      else begin
        check("a_data", 128'(dout_a), exp_qa[0]);
        check("a_latency", 128'(cyc), 128'(cyc_qa[0]));
        hold_a = exp_qa.pop_front();
        void'(cyc_qa.pop_front());
      end
    end else check("a_hold", 128'(dout_a), hold_a);
  end

  always @(negedge clk) begin
    if (rst) hold_b = '0;
    else if (vout_b) begin
      pulses_b++;
      if (exp_qb.size() == 0) check("b_unexpected", 128'(vout_b), '0);
      else begin
        check("b_data", 128'(dout_b), exp_qb[0]);
        check("b_latency", 128'(cyc), 128'(cyc_qb[0]));
        hold_b = exp_qb.pop_front();
        void'(cyc_qb.pop_front());
      end
    end else check("b_hold", 128'(dout_b), hold_b);
  end

  always @(negedge clk) begin
    if (rst) hold_c = '0;
    else if (vout_c) begin
      pulses_c++;
      if (exp_qc.size() == 0) check("c_unexpected", 128'(vout_c), '0);
      else begin
        check("c_data", 128'(dout_c), exp_qc[0]);
        check("c_latency", 128'(cyc), 128'(cyc_qc[0]));
        hold_c = exp_qc.pop_front();
        void'(cyc_qc.pop_front());
      end
    end else check("c_hold", 128'(dout_c), hold_c);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    @(posedge clk); #2;
    vld_a = 1'b0; last_a = 1'b0;
    vld_b = 1'b0; last_b = 1'b0;
    vld_c = 1'b0; last_c = 1'b0;
  endtask

  task automatic send_ac(input bit sel, input int w0, input int w1, input bit last);
    @(posedge clk); #2;
    if (!sel) begin
      vld_a = 1'b1; last_a = last; din_a = {12'(w1), 12'(w0)};
    end else begin
      vld_c = 1'b1; last_c = last; din_c = {12'(w1), 12'(w0)};
    end
    drive_cyc = cyc;
  endtask

  task automatic expect_ac(input bit sel, input int e0, input int e1);
    if (!sel) begin
      exp_qa.push_back(pack2(e0, e1));
      cyc_qa.push_back(drive_cyc + 2);
    end else begin
      exp_qc.push_back(pack2(e0, e1));
      cyc_qc.push_back(drive_cyc + 2);
    end
  endtask

  task automatic send_word_b(input logic [127:0] w, input logic [2:0] last_mask, input int nsl);
    int gaps;
    for (int s = 0; s < nsl; s++) begin
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        @(posedge clk); #2;
        vld_b = 1'b0; last_b = 1'b0;
      end
      @(posedge clk); #2;
      vld_b  = 1'b1;
      last_b = last_mask[s];
      for (int ch = 0; ch < 10; ch++) din_b[ch*4 +: 4] = w[ch*12 + s*4 +: 4];
      if (s == 2) drive_cyc = cyc;
    end
  endtask

  task automatic expect_b(input int row);
    exp_qb.push_back(pack_row(row));
    cyc_qb.push_back(drive_cyc + 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    vld_a = 1'b1; last_a = 1'b0; din_a = 24'h00F00F;
    vld_b = 1'b1; last_b = 1'b0; din_b = 40'h1234567890;
    vld_c = 1'b1; last_c = 1'b0; din_c = 24'h123456;

    // reset held with vld_in toggling and random data
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_vld_a", 128'(vout_a), '0);
      check("rst_dout_a", 128'(dout_a), '0);
      check("rst_vld_b", 128'(vout_b), '0);
      check("rst_dout_b", 128'(dout_b), '0);
      check("rst_vld_c", 128'(vout_c), '0);
      check("rst_dout_c", 128'(dout_c), '0);
      @(posedge clk); #2;
      vld_a = ~vld_a; din_a = 24'($urandom);
      vld_b = ~vld_b; din_b = {8'($urandom), 32'($urandom)};
      vld_c = ~vld_c; din_c = 24'($urandom);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;

    // max, POOL=4: full window, flushed window of 3, full window, all back-to-back
    send_ac(0, -3, 100, 0);  send_ac(0, 7, -50, 0);
    send_ac(0, 2, -200, 0);  send_ac(0, 7, 99, 0);   expect_ac(0, 7, 100);
    send_ac(0, 5, -1, 0);    send_ac(0, 9, -2, 0);
    send_ac(0, 1, -3, 1);                            expect_ac(0, 9, -1);
    send_ac(0, -8, 0, 0);    send_ac(0, -9, -1, 0);
    send_ac(0, -10, 5, 0);   send_ac(0, -11, 4, 0);  expect_ac(0, -8, 5);
    idle_all();
    repeat (3) @(posedge clk);

    // average, POOL=4: floor division, negative sums, flush counts missing words as zero
    send_ac(1, 1, 100, 0);   send_ac(1, 2, 100, 0);
    send_ac(1, 3, 100, 0);   send_ac(1, -1, 100, 0); expect_ac(1, 1, 100);
    send_ac(1, -1, -5, 0);   send_ac(1, -2, 0, 0);
    send_ac(1, -3, 0, 0);    send_ac(1, -1, 0, 0);   expect_ac(1, -2, -2);
    send_ac(1, 4, 7, 0);     send_ac(1, 4, 0, 0);
    send_ac(1, 4, 1, 1);                             expect_ac(1, 3, 2);
    idle_all();
    repeat (3) @(posedge clk);

    // serial max, POOL=2: extremes with random gaps between slices
    send_word_b(pack_row(0), 3'b000, 3);
    send_word_b(pack_row(1), 3'b000, 3);  expect_b(2);
    idle_all();
    // last_in on non-final slices of the first word must be ignored
    send_word_b(pack_row(3), 3'b011, 3);
    send_word_b(pack_row(4), 3'b000, 3);  expect_b(5);
    idle_all();
    repeat (2) @(posedge clk);

    // reset after one slice of the window's second word discards everything
    send_word_b(pack_row(0), 3'b000, 3);
    send_word_b(pack_row(1), 3'b000, 1);
    @(posedge clk); #2;
    vld_b = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    send_word_b(pack_row(3), 3'b000, 3);
    send_word_b(pack_row(4), 3'b000, 3);  expect_b(5);
    idle_all();

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("a_pulse_count", 128'(pulses_a), 128'(3));
    check("b_pulse_count", 128'(pulses_b), 128'(3));
    check("c_pulse_count", 128'(pulses_c), 128'(3));
    check("a_queue_empty", 128'(exp_qa.size()), '0);
    check("b_queue_empty", 128'(exp_qb.size()), '0);
    check("c_queue_empty", 128'(exp_qc.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
